vec_alu_sequencer: RTL and testbench

- Issuing master for the 18-bit scalar ALU in the Filter-GPU vector datapath.
- Accepts one vector request per handshake: LANES operand pairs plus one 3-bit opcode.
- Issues the lanes to a single combinational scalar ALU one per cycle, lane 0 first.
- Captures each lane's result and flags, then returns one vector response through a valid/ready handshake.

---
 rtl/vec_alu_sequencer.sv | 178 +++++++++++++++++
 tb/tb_vec_alu_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/vec_alu_sequencer.sv
// vec_alu_sequencer: issues one vector request to a single combinational
// scalar ALU, one lane per cycle (lane 0 first), gathers per-lane results
// and flags, and returns them as one vector response.
// Optional build macro: VSEQ_SATURATE_EN (saturating signed add, opcode 010).
module vec_alu_sequencer #(
   parameter int N     = 18,
   parameter int LANES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [2:0]           req_op,
   input  logic [LANES*N-1:0]   req_a,
   input  logic [LANES*N-1:0]   req_b,
   output logic [N-1:0]         alu_a,
   output logic [N-1:0]         alu_b,
   output logic [2:0]           alu_f,
   input  logic [N-1:0]         alu_result,
   input  logic                 alu_neg,
   input  logic                 alu_zero,
   input  logic                 alu_carry,
   input  logic                 alu_ovf,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [LANES*N-1:0]   rsp_result,
   output logic [LANES-1:0]     rsp_neg,
   output logic [LANES-1:0]     rsp_zero,
   output logic [LANES-1:0]     rsp_carry,
   output logic [LANES-1:0]     rsp_ovf,
   output logic                 rsp_all_zero,
   output logic                 rsp_any_ovf,
   output logic                 rsp_err
);

   localparam int KW = (LANES > 1) ? $clog2(LANES) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

   state_t               state_q, state_d;
   logic [KW-1:0]        k_q, k_d;
   logic [LANES*N-1:0]   a_q, a_d, b_q, b_d;
   logic [LANES*N-1:0]   res_q, res_d;
   logic [LANES-1:0]     neg_q, neg_d, zero_q, zero_d;
   logic [LANES-1:0]     carry_q, carry_d, ovf_q, ovf_d;
   logic                 err_q, err_d;
   logic [N-1:0]         alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [2:0]           alu_f_q, alu_f_d;
   logic [N-1:0]         lane_res;
   logic                 lane_ovf;

   // Per-lane value to capture: ALU output, optionally saturated on signed add overflow
   always_comb begin
      lane_res = alu_result;
      lane_ovf = alu_ovf;
`ifdef VSEQ_SATURATE_EN
      if (alu_f_q == 3'b010 && alu_a_q[N-1] == alu_b_q[N-1] &&
          alu_result[N-1] != alu_a_q[N-1]) begin
         lane_res = alu_a_q[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
         lane_ovf = 1'b1;
      end
`endif
   end

   // Next-state: accept in IDLE, one lane per cycle in ISSUE, hold in DONE
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      neg_d   = neg_q;
      zero_d  = zero_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      err_d   = err_q;
      alu_a_d = alu_a_q;
      alu_b_d = alu_b_q;
      alu_f_d = alu_f_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               a_d = req_a;
               b_d = req_b;
               k_d = '0;
               if (req_op > 3'd4) begin
                  // illegal opcode: skip the ALU entirely, answer with an error
                  alu_a_d = '0;
                  alu_b_d = '0;
                  alu_f_d = 3'b000;
                  res_d   = '0;
                  neg_d   = '0;
                  zero_d  = '0;
                  carry_d = '0;
                  ovf_d   = '0;
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  // lane 0 operands are registered on the accept edge
                  alu_a_d = req_a[N-1:0];
                  alu_b_d = req_b[N-1:0];
                  alu_f_d = req_op;
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            res_d[int'(k_q)*N +: N] = lane_res;
            neg_d[k_q]   = alu_neg;
            zero_d[k_q]  = alu_zero;
            carry_d[k_q] = alu_carry;
            ovf_d[k_q]   = lane_ovf;
            if (int'(k_q) == LANES-1) begin
               state_d = DONE;
            end else begin
               k_d     = k_q + KW'(1);
               alu_a_d = a_q[int'(k_d)*N +: N];
               alu_b_d = b_q[int'(k_d)*N +: N];
            end
         end
         DONE: begin
            if (rsp_ready) begin
               err_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers, synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         k_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         neg_q   <= '0;
         zero_q  <= '0;
         carry_q <= '0;
         ovf_q   <= '0;
         err_q   <= 1'b0;
         alu_a_q <= '0;
         alu_b_q <= '0;
         alu_f_q <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         neg_q   <= neg_d;
         zero_q  <= zero_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
         alu_a_q <= alu_a_d;
         alu_b_q <= alu_b_d;
         alu_f_q <= alu_f_d;
      end
   end

   assign req_ready    = (state_q == IDLE);
   assign rsp_valid    = (state_q == DONE);
   assign alu_a        = alu_a_q;
   assign alu_b        = alu_b_q;
   assign alu_f        = alu_f_q;
   assign rsp_result   = res_q;
   assign rsp_neg      = neg_q;
   assign rsp_zero     = zero_q;
   assign rsp_carry    = carry_q;
   assign rsp_ovf      = ovf_q;
   assign rsp_err      = err_q;
   assign rsp_all_zero = rsp_valid & (&zero_q);
   assign rsp_any_ovf  = rsp_valid & (|ovf_q);

endmodule

// File: tb/tb_vec_alu_sequencer.sv
// Self-checking bench for vec_alu_sequencer with a behavioural scalar ALU attached.
module tb_vec_alu_sequencer;
   localparam int N     = 18;
   localparam int LANES = 4;
   localparam int W     = LANES * N;

   logic             clk = 1'b0;
   logic             rst;
   logic             req_valid, req_ready;
   logic [2:0]       req_op;
   logic [W-1:0]     req_a, req_b;
   logic [N-1:0]     alu_a, alu_b, alu_result;
   logic [2:0]       alu_f;
   logic             alu_neg, alu_zero, alu_carry, alu_ovf;
   logic             rsp_valid, rsp_ready;
   logic [W-1:0]     rsp_result;
   logic [LANES-1:0] rsp_neg, rsp_zero, rsp_carry, rsp_ovf;
   logic             rsp_all_zero, rsp_any_ovf, rsp_err;

   int total = 0;
   int bad   = 0;

   logic [W-1:0]     exp_res;
   logic [LANES-1:0] exp_neg, exp_zero, exp_carry, exp_ovf;
   logic             exp_err;
   logic [N+3:0]     alu_t;

   always #5 clk = ~clk;

   vec_alu_sequencer #(.N(N), .LANES(LANES)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
      .alu_result(alu_result), .alu_neg(alu_neg), .alu_zero(alu_zero),
      .alu_carry(alu_carry), .alu_ovf(alu_ovf),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_neg(rsp_neg), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf),
      .rsp_all_zero(rsp_all_zero), .rsp_any_ovf(rsp_any_ovf), .rsp_err(rsp_err)
   );

   // scalar ALU: returns {neg, zero, carry, ovf, result}
   function automatic logic [N+3:0] alu_fn(input logic [2:0] f, input logic [N-1:0] a, input logic [N-1:0] b);
      logic [N:0]   s;
      logic [N-1:0] r;
      logic         c, v;
      s = '0; c = 1'b0; v = 1'b0; r = '0;
      case (f)
         3'd0: r = a & b;
         3'd1: r = a | b;
         3'd2: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[N-1:0]; c = s[N];
            v = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
         end
         3'd3: begin
            s = {1'b0, a} - {1'b0, b};
            r = s[N-1:0]; c = s[N];
            v = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
         end
         3'd4: r = a ^ b;
         default: r = '0;
      endcase
      return {r[N-1], (r == '0), c, v, r};
   endfunction

   always_comb begin
      alu_t      = alu_fn(alu_f, alu_a, alu_b);
      alu_result = alu_t[N-1:0];
      alu_ovf    = alu_t[N];
      alu_carry  = alu_t[N+1];
      alu_zero   = alu_t[N+2];
      alu_neg    = alu_t[N+3];
   end

   // expected vector response straight from the request
   task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [N+3:0] t;
      exp_res = '0; exp_neg = '0; exp_zero = '0; exp_carry = '0; exp_ovf = '0;
      exp_err = (op > 3'd4);
      if (!exp_err) begin
         for (int i = 0; i < LANES; i++) begin
            t = alu_fn(op, a[i*N +: N], b[i*N +: N]);
`ifdef VSEQ_SATURATE_EN
            if (op == 3'd2 && t[N]) t[N-1:0] = a[i*N+N-1] ? 18'h20000 : 18'h1FFFF;
`endif
            exp_res[i*N +: N] = t[N-1:0];
            exp_ovf[i]   = t[N];
            exp_carry[i] = t[N+1];
            exp_zero[i]  = t[N+2];
            exp_neg[i]   = t[N+3];
         end
      end
   endtask

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // drive one request, follow it to the response, hold backpressure, handshake
   task automatic run_req(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold, input bit intrude);
      int w, lat;
      logic [127:0] snap;
      w = 0;
      while (!req_ready && w < 50) begin @(negedge clk); w++; end
      chk("req_ready_idle", req_ready, 1'b1);
      model(op, a, b);
      rsp_ready = (hold == 0);
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
      @(negedge clk);
      req_valid = 1'b0;
      req_a = {$urandom, $urandom, $urandom};
      lat = 0;
      for (int i = 1; i <= LANES + 3; i++) begin
         if (rsp_valid) begin lat = i; break; end
         if (op <= 3'd4 && i <= LANES) begin
            chk("alu_f", alu_f, op);
            chk("alu_a", alu_a, a[(i-1)*N +: N]);
            chk("alu_b", alu_b, b[(i-1)*N +: N]);
         end
         @(negedge clk);
      end
      chk("latency", lat, (op > 3'd4) ? 1 : LANES + 1);
      if (op > 3'd4) chk("ill_alu", {alu_a, alu_b, alu_f}, '0);
      chk("rsp_result", rsp_result, exp_res);
      chk("rsp_flags", {rsp_neg, rsp_zero, rsp_carry, rsp_ovf}, {exp_neg, exp_zero, exp_carry, exp_ovf});
      chk("rsp_err", rsp_err, exp_err);
      chk("all_zero", rsp_all_zero, &exp_zero);
      chk("any_ovf", rsp_any_ovf, |exp_ovf);
      chk("done_ready", req_ready, 1'b0);
      snap = {rsp_result, rsp_neg, rsp_zero, rsp_carry, rsp_ovf, rsp_err, rsp_all_zero, rsp_any_ovf};
      for (int h = 0; h < hold; h++) begin
         if (intrude) begin
            req_valid = 1'b1; req_op = 3'd1; req_a = {$urandom, $urandom, $urandom};
         end
         @(negedge clk);
         chk("hold_valid", rsp_valid, 1'b1);
         chk("hold_stable", {rsp_result, rsp_neg, rsp_zero, rsp_carry, rsp_ovf, rsp_err,
                             rsp_all_zero, rsp_any_ovf}, snap);
         chk("hold_ready", req_ready, 1'b0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("post_valid", rsp_valid, 1'b0);
      chk("post_ready", req_ready, 1'b1);
      chk("post_err", rsp_err, 1'b0);
      chk("post_aggr", {rsp_all_zero, rsp_any_ovf}, 2'b00);
   endtask

   function automatic logic [W-1:0] pack4(input int l0, input int l1, input int l2, input int l3);
      logic [W-1:0] v;
      v = '0;
      v[0*N +: N] = N'(l0); v[1*N +: N] = N'(l1);
      v[2*N +: N] = N'(l2); v[3*N +: N] = N'(l3);
      return v;
   endfunction

   initial begin
      logic [W-1:0] ra, rb;
      logic [2:0]   rop;
      rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
      req_op = '0; req_a = '0; req_b = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", req_ready, 1'b1);
      chk("rst_valid_err", {rsp_valid, rsp_err}, 2'b00);
      chk("rst_alu", {alu_a, alu_b, alu_f}, '0);
      chk("rst_rsp", {rsp_result, rsp_neg, rsp_zero, rsp_carry, rsp_ovf, rsp_all_zero, rsp_any_ovf}, '0);
      rst = 1'b0;
      @(negedge clk);

      run_req(3'b010, pack4(1, 2, 3, 4), pack4(10, 20, 30, 40), 0, 1'b0);
      chk("add_lanes", rsp_result, pack4(11, 22, 33, 44));
      run_req(3'b000, {LANES{18'h3FFFF}}, '0, 2, 1'b0);
      run_req(3'b110, pack4(5, 6, 7, 8), pack4(1, 1, 1, 1), 3, 1'b1);
      run_req(3'b011, pack4(9, 0, 3, 'h20000), pack4(9, 1, 3, 1), 5, 1'b1);
      run_req(3'b010, pack4('h1FFFF, 'h20000, 7, 0), pack4(1, 'h20000, 8, 0), 1, 1'b0);
`ifdef VSEQ_SATURATE_EN
      chk("sat_lane0", {rsp_result[N-1:0], rsp_ovf[0]}, {18'h1FFFF, 1'b1});
`else
      chk("sat_lane0", {rsp_result[N-1:0], rsp_ovf[0]}, {18'h20000, 1'b1});
`endif

      // reset while lane 2 is in flight
      req_valid = 1'b1; req_op = 3'b010; req_a = pack4(1, 1, 1, 1); req_b = pack4(2, 2, 2, 2);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_state", {rsp_valid, req_ready}, 2'b01);
      chk("midrst_rsp", {rsp_result, rsp_err, alu_f}, '0);
      repeat (LANES + 2) @(negedge clk);
      chk("midrst_quiet", rsp_valid, 1'b0);

      for (int n = 0; n < 40; n++) begin
         rop = 3'($urandom_range(0, 7));
         for (int i = 0; i < LANES; i++) begin
            ra[i*N +: N] = N'($urandom);
            rb[i*N +: N] = ($urandom_range(0, 3) == 0) ? ra[i*N +: N] : N'($urandom);
         end
         run_req(rop, ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
